// File: rtl/tt_prbs_pkg.sv
// rtl/tt_prbs_pkg.sv - shared PRBS-4 constants, checker limits and FSM state encoding.
package tt_prbs_pkg;
  // XNOR taps on w[0] and w[1]: s[n+4] = ~(s[n] ^ s[n+1]).
  localparam logic [3:0] PRBS4_TAPS   = 4'b0011;
  localparam logic [3:0] PRBS4_LOCKUP = 4'b1111;
  localparam int         PRBS4_PERIOD = 15;

  localparam int               CNT_W     = 8;
  localparam int               WIN       = 16;
  localparam logic [3:0]       LOCK_CNT  = 4'd8;
  localparam logic [2:0]       ERR_LIMIT = 3'd4;
  localparam logic [3:0]       WIN_LAST  = 4'(WIN - 1);
  localparam logic [1:0]       FILL_LAST = 2'd3;
  localparam logic [CNT_W-1:0] ERR_MAX   = '1;
  localparam logic [CNT_W-1:0] ERR_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;
endpackage

// File: rtl/prbs4_predictor.sv
// rtl/prbs4_predictor.sv - 4-bit PRBS window (w[0] oldest) with XNOR next-bit prediction.
module prbs4_predictor
  import tt_prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [3:0] w,
  output logic       exp
);
  logic [3:0] w_q, w_d;

  always_comb begin
    w_d = w_q;
    if (shift_en) w_d = {bit_in, w_q[3:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= '0;
    else        w_q <= w_d;
  end

  assign w   = w_q;
  assign exp = ~^(w_q & PRBS4_TAPS);
endmodule

// File: rtl/tt_um_prbs4_stream_checker.sv
// rtl/tt_um_prbs4_stream_checker.sv - PRBS-4 stream checker tile: lock FSM, windowed error
// counting and pin mapping.
module tt_um_prbs4_stream_checker
  import tt_prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic bit_in, bit_valid, clr_err, mismatch, exp_bit;
  logic [3:0] w;

  assign bit_in    = ui_in[0];
  assign bit_valid = ui_in[1];
  assign clr_err   = ui_in[2];

  prbs4_predictor u_pred (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (bit_valid),
    .bit_in   (bit_in),
    .w        (w),
    .exp      (exp_bit)
  );

  assign mismatch = bit_in ^ exp_bit;

  state_e           state_q, state_d;
  logic [1:0]       fill_cnt_q, fill_cnt_d;
  logic [3:0]       run_cnt_q, run_cnt_d;
  logic [3:0]       win_cnt_q, win_cnt_d;
  logic [2:0]       win_err_q, win_err_d, win_err_nx;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    run_cnt_d   = run_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    win_err_nx  = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    if (bit_valid) begin
      if (clr_err) err_cnt_d = '0;
      case (state_q)
        ST_TRAIN: begin
          // The all-ones window is the XNOR lock-up state; never accept it as a lock.
          if (w == PRBS4_LOCKUP || mismatch) begin
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 4'd1;
            if (run_cnt_d == LOCK_CNT) begin
              state_d   = ST_LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (!clr_err && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_ONE;
          end
          // An error on the wrapping bit belongs to the new window.
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d  = '0;
            win_err_nx = {2'b00, mismatch};
          end else begin
            win_cnt_d  = win_cnt_q + 4'd1;
            win_err_nx = win_err_q + {2'b00, mismatch};
          end
          win_err_d = win_err_nx;
          if (win_err_nx == ERR_LIMIT) begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end
        end
        default: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_d    = ST_TRAIN;
            fill_cnt_d = '0;
            run_cnt_d  = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      run_cnt_q   <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      run_cnt_q   <= run_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign uo_out  = {w, state_q, err_pulse_q, (state_q == ST_LOCKED)};
  assign uio_out = err_cnt_q;
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};
endmodule
